// File: rtl/run_trace_pkg.sv
// Shared types and helpers for the run controller and its trace buffer.
package run_trace_pkg;

    // Controller phases: idle, holding the core in reset, running, finished.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESET_HOLD = 2'd1,
        RUN        = 2'd2,
        DONE       = 2'd3
    } run_state_t;

    // Default datapath width of one traced core signal.
    localparam int TRACE_DATA_W = 32;

    // One trace record; the buffer stores it packed as {pc, alu}.
    typedef struct packed {
        logic [TRACE_DATA_W-1:0] pc;
        logic [TRACE_DATA_W-1:0] alu;
    } trace_entry_t;

    // Width of an occupancy count that can reach depth itself (0..depth).
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is presented
// combinationally from the storage array, so readout needs no prefetch.
// Pointers carry one extra bit so full and empty are distinguishable.
module trace_fifo
    import run_trace_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = level_width(DEPTH)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic         do_push;
    logic         do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A pop frees the head slot in the same edge, so a full FIFO may still
    // accept a push when it is being popped.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign level = wr_ptr_reg - rd_ptr_reg;
    assign dout  = mem[rd_ptr_reg[AW-1:0]];

    // Pointer update; a clear discards all contents and wins over push/pop.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/run_trace_ctrl.sv
// Run controller for the pipelined core: sequences core reset, runs the core
// for a bounded number of cycles or until a halt PC, and records one
// {pc, alu_output} sample per run cycle into a readable trace buffer.
module run_trace_ctrl
    import run_trace_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = 2,
    localparam int LVL_W     = level_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  run_cycles,
    input  logic              halt_en,
    input  logic [DATA_W-1:0] halt_pc,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] alu_output,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic              overflow,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [LVL_W-1:0]  trace_level,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [DATA_W-1:0] trace_pc,
    output logic [DATA_W-1:0] trace_alu
);

    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_t          state_reg, state_next;
    logic [HW-1:0]       hold_cnt_reg, hold_cnt_next;
    logic [CNT_W-1:0]    cycle_count_reg, cycle_count_next;
    logic [CNT_W-1:0]    run_cycles_reg;
    logic                halt_en_reg;
    logic [DATA_W-1:0]   halt_pc_reg;
    logic                halted_reg, halted_next;
    logic                overflow_reg;
    logic                launch;
    logic                capture;
    logic                fifo_full;
    logic                fifo_empty;
    logic [2*DATA_W-1:0] fifo_dout;

    // Next-state logic: launch from IDLE/DONE, timed reset hold, run with
    // limit and PC-match termination (a halt match also records its sample).
    always_comb begin
        state_next       = state_reg;
        hold_cnt_next    = hold_cnt_reg;
        cycle_count_next = cycle_count_reg;
        halted_next      = halted_reg;
        launch           = 1'b0;
        capture          = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    launch           = 1'b1;
                    hold_cnt_next    = '0;
                    cycle_count_next = '0;
                    halted_next      = 1'b0;
                    // A zero-length run finishes without releasing the core.
                    state_next = (run_cycles == '0) ? DONE : RESET_HOLD;
                end
            end
            RESET_HOLD: begin
                if (hold_cnt_reg == HW'(RST_CYCLES - 1)) begin
                    hold_cnt_next = '0;
                    state_next    = RUN;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HW'(1);
                end
            end
            RUN: begin
                capture          = 1'b1;
                cycle_count_next = cycle_count_reg + CNT_W'(1);
                if (halt_en_reg && (pc == halt_pc_reg)) begin
                    halted_next = 1'b1;
                    state_next  = DONE;
                end else if (cycle_count_next == run_cycles_reg) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and run counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            hold_cnt_reg    <= '0;
            cycle_count_reg <= '0;
            halted_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            hold_cnt_reg    <= hold_cnt_next;
            cycle_count_reg <= cycle_count_next;
            halted_reg      <= halted_next;
        end
    end

    // Run configuration is captured only when a run is launched.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cycles_reg <= '0;
            halt_en_reg    <= 1'b0;
            halt_pc_reg    <= '0;
        end else if (launch) begin
            run_cycles_reg <= run_cycles;
            halt_en_reg    <= halt_en;
            halt_pc_reg    <= halt_pc;
        end
    end

    // Sticky drop flag: a capture into a full buffer with no pop to make room.
    always_ff @(posedge clk) begin
        if (reset || launch) begin
            overflow_reg <= 1'b0;
        end else if (capture && fifo_full && !trace_ready) begin
            overflow_reg <= 1'b1;
        end
    end

    trace_fifo #(
        .W     (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_trace_fifo (
        .clk   (clk),
        .srst  (reset),
        .clear (launch),
        .push  (capture),
        .pop   (trace_ready),
        .din   ({pc, alu_output}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (trace_level)
    );

    assign core_reset  = (state_reg != RUN);
    assign busy        = (state_reg == RESET_HOLD) || (state_reg == RUN);
    assign done        = (state_reg == DONE);
    assign halted      = halted_reg;
    assign overflow    = overflow_reg;
    assign cycle_count = cycle_count_reg;
    assign trace_valid = !fifo_empty;
    assign trace_pc    = fifo_dout[2*DATA_W-1:DATA_W];
    assign trace_alu   = fifo_dout[DATA_W-1:0];

endmodule

// File: doc/run_trace_ctrl.md
Name: run_trace_ctrl

Overview:
- Synthesizable run controller and trace capture for the pipelined core top.
- Sequences the core's reset, lets the core run for a programmable number of cycles or until a halt PC, and captures per-cycle {PC, ALU_output} into an on-chip trace buffer.
- Provides a valid/ready readout port for the buffer.
- Replaces hand-timed clock/reset stimulus with a parametrised, repeatable run/observe mechanism usable on silicon and in simulation.

Parameters:
- DATA_W, 32: width of PC and ALU_output.
- DEPTH, 16: trace entries; power of two, ≥2.
- CNT_W, 16: width of run-cycle limit and cycle counter.
- RST_CYCLES, 2: cycles core_reset is held after start; ≥1.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset for this block.
- start  in  1  one-cycle request to begin a run.
- run_cycles  in  CNT_W  maximum RUN cycles; latched at start.
- halt_en  in  1  enable PC-match stop; latched at start.
- halt_pc  in  DATA_W  stop PC; latched at start.
- pc  in  DATA_W  core PC.
- alu_output  in  DATA_W  core ALU result.
- core_reset  out  1  reset to core; active-high.
- busy  out  1  high in RESET_HOLD and RUN.
- done  out  1  high in DONE.
- halted  out  1  run ended by PC match.
- overflow  out  1  sticky; a sample was dropped because the buffer was full.
- cycle_count  out  CNT_W  RUN cycles elapsed in the current/last run.
- trace_level  out  $clog2(DEPTH)+1  entries held.
- trace_valid  out  1  buffer non-empty.
- trace_ready  in  1  pop request.
- trace_pc  out  DATA_W  head entry PC (first-word fall-through).
- trace_alu  out  DATA_W  head entry ALU value.

Behaviour:
- Reset values (next edge with reset=1): state IDLE; core_reset=1; busy=0; done=0; halted=0; overflow=0; cycle_count=0; buffer empty; trace_valid=0.
  - Reset mid-run aborts immediately; latched config is don't-care.
- States: IDLE, RESET_HOLD, RUN, DONE.
- core_reset is 1 in all states except RUN.
- IDLE or DONE with start=1:
  - Latch run_cycles, halt_en and halt_pc.
  - Clear buffer, overflow, halted, done and cycle_count. Clear wins over a same-cycle pop.
  - Go to RESET_HOLD, or to DONE if run_cycles==0, in which case core_reset never deasserts.
- start while busy is ignored.
- RESET_HOLD:
  - Internal counter holds for exactly RST_CYCLES cycles, then goes to RUN.
- RUN, on each edge:
  - Capture {pc, alu_output} into the buffer.
  - cycle_count += 1.
  - If cycle_count+1 == latched run_cycles, go to DONE.
  - If halt_en and pc==halt_pc, capture the matching sample, set halted=1 and go to DONE.
  - Halt and limit in the same cycle: DONE with halted=1.
  - cycle_count saturates by construction (≤ run_cycles).
- Buffer full during capture:
  - Without a same-cycle pop: drop the new sample and set overflow=1. Oldest DEPTH entries are kept.
  - With a same-cycle pop: accept the push; level unchanged; no overflow.
- Readout:
  - Pop occurs on trace_valid & trace_ready.
  - Legal in any state, including during RUN.
  - Pop when empty has no effect.
  - trace_pc and trace_alu are valid only while trace_valid=1.
- trace_level updates on the edge after a push or pop. Range is 0..DEPTH.
- Buffer pointers wrap modulo DEPTH; full/empty are distinguished by the extra pointer bit.

Decomposition:
- Package run_trace_pkg: state enum (IDLE, RESET_HOLD, RUN, DONE); trace_entry struct {pc, alu} of 2*DATA_W; localparam for level width.
- Sub-module trace_fifo: synchronous FWFT FIFO, DEPTH x 2*DATA_W, with push/pop/full/empty/level and a sync clear input.
- Top-level FSM and counters live in run_trace_ctrl.

Test Plan:
- Basic run: RST_CYCLES=2, run_cycles=5, halt_en=0, core PC stepping by 4 from 0 → core_reset=1 for 2 cycles after start, then 0 for exactly 5 cycles. Then done=1, cycle_count=5, trace_level=5, and pops return PC 0,4,8,12,16 with matching ALU values.
- Halt: halt_en=1, halt_pc=0x0000000C, run_cycles=100 → DONE with halted=1, cycle_count=4, trace_level=4; last entry PC=0x0C; core_reset=1 afterwards.
- Overflow: DEPTH=16, run_cycles=20, trace_ready=0 → trace_level=16, overflow=1; popped PCs are the first 16 samples in order.
- Full with simultaneous pop: fill to 16, then hold trace_ready=1 during further captures → overflow stays 0, level stays 16, no sample lost.
- Reset mid-run: assert reset at RUN cycle 3 → next edge core_reset=1, busy=0, done=0, trace_level=0, trace_valid=0.
- Edge starts: start with run_cycles=0 → done=1 next cycle, core_reset never 0, level 0. start pulsed during RUN → ignored; counts unchanged. Re-start from DONE → buffer and flags cleared.
